// File: rtl/mem_xfer_if.sv
// ============================================================================
// Module   : mem_xfer_if
// Purpose  : Bus, control and memory handshake bundle for mem_xfer_ctrl.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface mem_xfer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  // Shared internal bus side
  logic [DATA_W-1:0] bus_in;
  logic [DATA_W-1:0] bus_out;
  logic              bus_oe;
  // Control unit side
  logic              mar_load;
  logic              mdr_load;
  logic              mdr_out_en;
  logic              start;
  logic              rw;
  logic              inc;
  logic              busy;
  logic              done;
  logic              err;
  // Memory side
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_en;
  logic              mem_rw;
  logic              mem_mfc;

  modport slave (
    input  bus_in, mar_load, mdr_load, mdr_out_en, start, rw, inc,
           mem_rdata, mem_mfc,
    output bus_out, bus_oe, busy, done, err,
           mem_addr, mem_wdata, mem_en, mem_rw
  );

  modport master (
    output bus_in, mar_load, mdr_load, mdr_out_en, start, rw, inc,
           mem_rdata, mem_mfc,
    input  bus_out, bus_oe, busy, done, err,
           mem_addr, mem_wdata, mem_en, mem_rw
  );
endinterface

`default_nettype wire

// File: rtl/mem_xfer_ctrl.sv
// ============================================================================
// Module   : mem_xfer_ctrl
// Purpose  : MAR/MDR holder sequencing one EN/R_W/MFC memory transfer with
//            bounded timeout, MAR post-increment and done/err status.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_xfer_ctrl #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  wire logic clk,
  input  wire logic reset,
  mem_xfer_if.slave xif
);

  localparam int               CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_REL  = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mar_q,   mar_d;
  logic [DATA_W-1:0] mdr_q,   mdr_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              rw_q,    rw_d;
  logic              inc_q,   inc_d;
  logic              err_q,   err_d;
  logic [ADDR_W-1:0] mar_src;

  // MAR takes the low bus bits; a bus narrower than the address zero-extends.
  generate
    if (ADDR_W <= DATA_W) begin : g_mar_slice
      assign mar_src = xif.bus_in[ADDR_W-1:0];
    end else begin : g_mar_zext
      assign mar_src = {{(ADDR_W-DATA_W){1'b0}}, xif.bus_in};
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      cnt_q   <= '0;
      rw_q    <= 1'b1;
      inc_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      inc_q   <= inc_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    inc_d   = inc_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        // Loads land together with start so the transfer sees the new values.
        if (xif.mar_load) mar_d = mar_src;
        if (xif.mdr_load) mdr_d = xif.bus_in;
        if (xif.start) begin
          rw_d    = xif.rw;
          inc_d   = xif.inc;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_REQ;
        end
      end

      ST_REQ: begin
        if (xif.mem_mfc) begin
          if (rw_q) mdr_d = xif.mem_rdata;
          cnt_d   = '0;
          state_d = ST_REL;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_FIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_REL: begin
        if (!xif.mem_mfc) begin
          if (inc_q) mar_d = mar_q + ADDR_W'(1);
          state_d = ST_FIN;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_FIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_FIN: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign xif.busy      = (state_q != ST_IDLE);
  assign xif.done      = (state_q == ST_FIN);
  assign xif.err       = err_q;
  assign xif.mem_en    = (state_q == ST_REQ);
  assign xif.mem_rw    = (state_q == ST_REQ) ? rw_q : 1'b1;
  assign xif.mem_addr  = mar_q;
  assign xif.mem_wdata = mdr_q;
  assign xif.bus_out   = mdr_q;
  assign xif.bus_oe    = xif.mdr_out_en & ~xif.busy;

endmodule

`default_nettype wire

// File: tb/tb_mem_xfer_ctrl.sv
// ============================================================================
// Module   : tb_mem_xfer_ctrl
// Purpose  : Directed plus randomized bench for mem_xfer_ctrl against a
//            timing/memory model derived from the transfer rules.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_xfer_ctrl;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 16;
  localparam int TIMEOUT = 15;

  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_xfer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) xif ();

  mem_xfer_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .xif   (xif)
  );

  int          vectors;
  int          miscompares;
  logic [15:0] exp_mar;
  logic [15:0] exp_mdr;
  logic        exp_err;
  logic [15:0] mem_model [logic [15:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    xif.bus_in     = '0;
    xif.mar_load   = 1'b0;
    xif.mdr_load   = 1'b0;
    xif.mdr_out_en = 1'b0;
    xif.start      = 1'b0;
    xif.rw         = 1'b1;
    xif.inc        = 1'b0;
    xif.mem_rdata  = '0;
    xif.mem_mfc    = 1'b0;
  endtask

  task automatic load_mar(input logic [15:0] v);
    xif.bus_in   = v;
    xif.mar_load = 1'b1;
    cyc();
    xif.mar_load = 1'b0;
    exp_mar      = v;
    chk("mar_load", xif.mem_addr, exp_mar);
  endtask

  task automatic load_mdr(input logic [15:0] v);
    xif.bus_in   = v;
    xif.mdr_load = 1'b1;
    cyc();
    xif.mdr_load = 1'b0;
    exp_mdr      = v;
    chk("mdr_load", xif.mem_wdata, exp_mdr);
  endtask

  // One transfer. MFC is high for cycles a..a+h-1 counted from the first
  // cycle after the start edge; the expected outcome comes from that window.
  task automatic xfer(input logic rw_i, input logic inc_i, input int a, input int h,
                      input logic ld_at_start, input logic [15:0] ld_val, input logic poke);
    int          exp_en, t_fin, en_cnt, t_done;
    logic [15:0] rdata, nmar, nmdr;
    logic        nerr;

    if (ld_at_start) exp_mar = ld_val;
    if (rw_i) begin
      if (mem_model.exists(exp_mar)) rdata = mem_model[exp_mar];
      else begin
        rdata = 16'($urandom);
        mem_model[exp_mar] = rdata;
      end
    end else begin
      rdata = 16'($urandom);
    end

    nmar = exp_mar;
    nmdr = exp_mdr;
    if (a > TIMEOUT) begin
      exp_en = TIMEOUT;
      t_fin  = TIMEOUT + 1;
      nerr   = 1'b1;
    end else begin
      exp_en = a;
      if (rw_i) nmdr = rdata;
      else      mem_model[exp_mar] = exp_mdr;
      if (h > TIMEOUT) begin
        nerr  = 1'b1;
        t_fin = a + 1 + TIMEOUT;
      end else begin
        nerr  = 1'b0;
        t_fin = a + h + 1;
        if (inc_i) nmar = exp_mar + 16'd1;
      end
    end

    xif.start     = 1'b1;
    xif.rw        = rw_i;
    xif.inc       = inc_i;
    xif.mem_mfc   = 1'b0;
    xif.mem_rdata = rdata;
    if (ld_at_start) begin
      xif.bus_in   = ld_val;
      xif.mar_load = 1'b1;
    end
    cyc();
    xif.start    = 1'b0;
    xif.mar_load = 1'b0;

    en_cnt = 0;
    t_done = -1;
    for (int t = 1; t <= 2 * TIMEOUT + 8; t++) begin
      xif.mem_mfc    = (t >= a) && (t < a + h);
      xif.mdr_out_en = 1'($urandom_range(0, 1));
      if (t == 1 && poke) begin
        xif.start    = 1'b1;
        xif.mar_load = 1'b1;
        xif.mdr_load = 1'b1;
        xif.bus_in   = 16'd3;
      end else if (t == 2) begin
        xif.start    = 1'b0;
        xif.mar_load = 1'b0;
        xif.mdr_load = 1'b0;
      end
      #1;
      if (xif.mem_en === 1'b1) begin
        en_cnt++;
        if (t == 1) begin
          chk("req_rw", xif.mem_rw, rw_i);
          chk("req_addr", xif.mem_addr, exp_mar);
          chk("req_wdata", xif.mem_wdata, exp_mdr);
        end
      end
      if (t == 1) chk("busy_oe", {xif.busy, xif.bus_oe}, 2'b10);
      if (xif.done === 1'b1) begin
        t_done = t;
        break;
      end
      cyc();
    end

    chk("done_seen", (t_done != -1), 1);
    chk("done_time", t_done, t_fin);
    chk("en_cycles", en_cnt, exp_en);
    chk("fin_err", xif.err, nerr);
    chk("fin_busy", xif.busy, 1'b1);

    exp_mar = nmar;
    exp_mdr = nmdr;
    exp_err = nerr;
    xif.mem_mfc    = 1'b0;
    xif.mdr_out_en = 1'b0;
    xif.start      = 1'b0;
    xif.mar_load   = 1'b0;
    xif.mdr_load   = 1'b0;
    cyc();
    chk("post_done", xif.done, 1'b0);
    chk("post_busy", xif.busy, 1'b0);
    chk("post_en_rw", {xif.mem_en, xif.mem_rw}, 2'b01);
    chk("post_mar", xif.mem_addr, exp_mar);
    chk("post_mdr", xif.bus_out, exp_mdr);
    chk("post_err", xif.err, exp_err);
    if (poke) begin
      cyc();
      chk("poke_no_requeue", {xif.busy, xif.done}, 2'b00);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    exp_mar     = '0;
    exp_mdr     = '0;
    exp_err     = 1'b0;
    idle_inputs();

    // Reset state
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mar", xif.mem_addr, 16'h0);
    chk("rst_mdr", xif.bus_out, 16'h0);
    chk("rst_ctl", {xif.mem_en, xif.mem_rw, xif.busy, xif.done, xif.err, xif.bus_oe}, 6'b010000);
    @(negedge clk);
    reset = 1'b1;
    cyc();

    // Write then read back through MDR
    load_mar(16'd7);
    load_mdr(16'd15);
    xfer(1'b0, 1'b0, 3, 1, 1'b0, 16'h0, 1'b0);
    chk("wr_mem", mem_model[16'd7], 16'd15);
    load_mdr(16'd0);
    xfer(1'b1, 1'b0, 2, 2, 1'b0, 16'h0, 1'b0);
    xif.mdr_out_en = 1'b1;
    #1;
    chk("rd_bus_out", xif.bus_out, 16'd15);
    chk("rd_bus_oe", xif.bus_oe, 1'b1);
    xif.mdr_out_en = 1'b0;

    // Auto-increment wrap, then no increment
    load_mar(16'hFFFF);
    xfer(1'b1, 1'b1, 1, 1, 1'b0, 16'h0, 1'b0);
    chk("inc_wrap", xif.mem_addr, 16'h0000);
    load_mar(16'hFFFF);
    xfer(1'b1, 1'b0, 1, 1, 1'b0, 16'h0, 1'b0);
    chk("no_inc", xif.mem_addr, 16'hFFFF);

    // Request timeout, then error cleared by a good transfer
    load_mdr(16'hA5A5);
    xfer(1'b1, 1'b1, TIMEOUT + 5, 1, 1'b0, 16'h0, 1'b0);
    chk("to_err", xif.err, 1'b1);
    chk("to_mdr", xif.bus_out, 16'hA5A5);
    xfer(1'b0, 1'b0, 2, 1, 1'b0, 16'h0, 1'b0);
    chk("err_clear", xif.err, 1'b0);

    // Release timeout with MFC stuck high
    load_mar(16'h0100);
    xfer(1'b1, 1'b1, 1, 60, 1'b0, 16'h0, 1'b0);
    chk("rel_to_mar", xif.mem_addr, 16'h0100);

    // Boundary: MFC on the last allowed cycle of each phase
    xfer(1'b1, 1'b1, TIMEOUT, TIMEOUT, 1'b0, 16'h0, 1'b0);

    // Busy protection and load coincident with start
    xfer(1'b1, 1'b0, 4, 2, 1'b0, 16'h0, 1'b1);
    xfer(1'b0, 1'b0, 1, 1, 1'b1, 16'd9, 1'b0);
    chk("start_load_addr", xif.mem_addr, 16'd9);

    // Asynchronous reset in the middle of a request
    xif.start = 1'b1;
    xif.rw    = 1'b1;
    cyc();
    xif.start = 1'b0;
    cyc();
    chk("mid_req_en", xif.mem_en, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_ctl", {xif.mem_en, xif.mem_rw, xif.busy, xif.done, xif.err}, 5'b01000);
    chk("arst_mar", xif.mem_addr, 16'h0);
    exp_mar = '0;
    exp_mdr = '0;
    exp_err = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("arst_no_done", {xif.busy, xif.done}, 2'b00);
    end

    // Randomized transfers
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) load_mar(16'($urandom_range(0, 7)) | (($urandom_range(0, 1) == 1) ? 16'hFFF8 : 16'h0));
      if ($urandom_range(0, 2) == 0) load_mdr(16'($urandom));
      xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           int'($urandom_range(1, TIMEOUT + 2)), int'($urandom_range(1, TIMEOUT + 2)),
           ($urandom_range(0, 5) == 0), 16'($urandom), ($urandom_range(0, 4) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
